conv_layer_scheduler: RTL and testbench

//  Sequences the shared 5x5 FP16 column-parallel convolution engine across NUM_CHANNELS kernels for one image.
//  - Per channel: streams 25 weights from weight RAM (kernel_load phase).
//  - Then fetches IMAGE_SIZE image columns from the 256-bit image RAM, two words per column.
//  - Tags each engine result column with (channel, column) for the feature-map writer.

---
 rtl/conv_layer_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_conv_layer_scheduler.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_scheduler.sv
// Sequences the 5x5 conv engine over NUM_CHANNELS kernels: weight load, column fetch, result tagging.
// Optional perf counters (cyc_count, ch_count) are built when SCHED_PERF_EN is defined.
module conv_layer_scheduler #(
  parameter int DATA_WIDTH   = 16,
  parameter int KERNEL_SIZE  = 5,
  parameter int IMAGE_SIZE   = 28,
  parameter int NUM_CHANNELS = 4,
  parameter int MEM_WIDTH    = 256,
  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic                             err,
  output logic                             w_rd_en,
  output logic [7:0]                       w_addr,
  input  logic [DATA_WIDTH-1:0]            w_rd_data,
  output logic                             img_rd_en,
  output logic [11:0]                      img_addr,
  input  logic [MEM_WIDTH-1:0]             img_rd_data,
  output logic                             eng_kernel_load,
  output logic [DATA_WIDTH-1:0]            eng_weight,
  output logic                             eng_col_valid,
  output logic [DATA_WIDTH*IMAGE_SIZE-1:0] eng_col,
  input  logic                             eng_out_valid,
  output logic                             out_valid,
  output logic [CH_W-1:0]                  out_ch,
  output logic [4:0]                       out_col,
`ifdef SCHED_PERF_EN
  output logic [31:0]                      cyc_count,
  output logic [7:0]                       ch_count,
`endif
  input  logic                             out_ready
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_W  = 3'd1;
  localparam logic [2:0] S_FETCH   = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_NEXT_CH = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam int KK      = KERNEL_SIZE * KERNEL_SIZE;
  localparam int NOUT    = IMAGE_SIZE - KERNEL_SIZE + 1;
  localparam int NRD     = 2 * IMAGE_SIZE;
  localparam int LANES   = MEM_WIDTH / DATA_WIDTH;
  localparam int HI_ROWS = IMAGE_SIZE - LANES;
  localparam int COLW    = DATA_WIDTH * IMAGE_SIZE;

  logic [2:0]      state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [7:0]      k_q, k_d;
  logic [6:0]      f_q, f_d;
  logic [4:0]      cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            kl_q, kl_d;
  logic            rd_q, rd_d;
  logic            rd_half_q, rd_half_d;
  logic            col_valid_q, col_valid_d;
  logic [COLW-1:0] col_q, col_d;
  logic            in_res;

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    k_d         = k_q;
    f_d         = f_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    col_d       = col_q;
    col_valid_d = 1'b0;
    in_res      = (state_q == S_FETCH) || (state_q == S_DRAIN);
    out_valid   = eng_out_valid && in_res;
    w_rd_en     = (state_q == S_LOAD_W) && (k_q < 8'(KK));
    img_rd_en   = (state_q == S_FETCH) && (f_q < 7'(NRD));
    kl_d        = w_rd_en;
    rd_d        = img_rd_en;
    rd_half_d   = f_q[0];

    // Even address returns the top 16 rows; odd address completes the column.
    if (rd_q) begin
      if (!rd_half_q) begin
        col_d[0 +: LANES*DATA_WIDTH] = img_rd_data[0 +: LANES*DATA_WIDTH];
      end else begin
        col_d[LANES*DATA_WIDTH +: HI_ROWS*DATA_WIDTH] = img_rd_data[0 +: HI_ROWS*DATA_WIDTH];
        col_valid_d = 1'b1;
      end
    end

    // Results are counted even when the writer drops them: the engine cannot stall.
    if (out_valid) cnt_d = cnt_q + 5'd1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD_W;
          ch_d    = '0;
          k_d     = '0;
          f_d     = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_LOAD_W: begin
        if (k_q == 8'(KK)) begin
          state_d = S_FETCH;
          f_d     = '0;
        end else begin
          k_d = k_q + 8'd1;
        end
      end
      S_FETCH: begin
        if (f_q < 7'(NRD)) f_d = f_q + 7'd1;
        if ((f_q == 7'(NRD)) && col_valid_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (cnt_d == 5'(NOUT)) state_d = S_NEXT_CH;
      end
      S_NEXT_CH: begin
        cnt_d = '0;
        k_d   = '0;
        if (ch_q == CH_W'(NUM_CHANNELS - 1)) begin
          state_d = S_DONE;
        end else begin
          ch_d    = ch_q + 1'b1;
          state_d = S_LOAD_W;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if ((out_valid && !out_ready) || (eng_out_valid && !in_res)) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      k_q         <= '0;
      f_q         <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      kl_q        <= 1'b0;
      rd_q        <= 1'b0;
      rd_half_q   <= 1'b0;
      col_valid_q <= 1'b0;
      col_q       <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      k_q         <= k_d;
      f_q         <= f_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      kl_q        <= kl_d;
      rd_q        <= rd_d;
      rd_half_q   <= rd_half_d;
      col_valid_q <= col_valid_d;
      col_q       <= col_d;
    end
  end

  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_DONE);
  assign err             = err_q;
  assign w_addr          = 8'(int'(ch_q) * KK + int'(k_q));
  assign img_addr        = 12'(f_q);
  assign eng_kernel_load = kl_q;
  assign eng_weight      = kl_q ? w_rd_data : '0;
  assign eng_col_valid   = col_valid_q;
  assign eng_col         = col_q;
  assign out_ch          = out_valid ? ch_q : '0;
  assign out_col         = out_valid ? cnt_q : '0;

`ifdef SCHED_PERF_EN
  logic [31:0] cyc_q, cyc_d;
  logic [7:0]  chc_q, chc_d;

  always_comb begin
    cyc_d = cyc_q;
    chc_d = chc_q;
    if ((state_q == S_IDLE) && start) cyc_d = '0;
    else if (busy)                    cyc_d = cyc_q + 32'd1;
    if (state_q == S_NEXT_CH) chc_d = chc_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q <= '0;
      chc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      chc_q <= chc_d;
    end
  end

  assign cyc_count = cyc_q;
  assign ch_count  = chc_q;
`endif
endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Bench for conv_layer_scheduler: RAM and engine models, random weights/image, queue-based reference checks.
module tb_conv_layer_scheduler;
  localparam int DW = 16, KS = 5, IMG = 28, NCH = 4, MW = 256;
  localparam int COLW = DW * IMG, KK = KS * KS, NOUT = IMG - KS + 1;

  logic clk = 1'b0;
  logic rst;
  logic start, busy, done, err;
  logic w_rd_en, img_rd_en, eng_kernel_load, eng_col_valid, eng_out_valid, out_valid, out_ready;
  logic [7:0] w_addr;
  logic [11:0] img_addr;
  logic [DW-1:0] w_rd_data, eng_weight;
  logic [MW-1:0] img_rd_data;
  logic [COLW-1:0] eng_col;
  logic [1:0] out_ch;
  logic [4:0] out_col;
`ifdef SCHED_PERF_EN
  logic [31:0] cyc_count;
  logic [7:0] ch_count;
`endif

  always #5 clk = ~clk;

  conv_layer_scheduler #(.DATA_WIDTH(DW), .KERNEL_SIZE(KS), .IMAGE_SIZE(IMG),
                         .NUM_CHANNELS(NCH), .MEM_WIDTH(MW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rd_data(w_rd_data),
    .img_rd_en(img_rd_en), .img_addr(img_addr), .img_rd_data(img_rd_data),
    .eng_kernel_load(eng_kernel_load), .eng_weight(eng_weight),
    .eng_col_valid(eng_col_valid), .eng_col(eng_col), .eng_out_valid(eng_out_valid),
    .out_valid(out_valid), .out_ch(out_ch), .out_col(out_col),
`ifdef SCHED_PERF_EN
    .cyc_count(cyc_count), .ch_count(ch_count),
`endif
    .out_ready(out_ready));

  int checks = 0, failures = 0;
  logic [DW-1:0] wmem [256];
  logic [DW-1:0] img [IMG][IMG];

  logic start_main = 1'b0, start_extra = 1'b0, inject = 1'b0;
  logic dist_en = 1'b0, drop_en = 1'b0;
  int drop_tag = 0;
  int tag_total = 0, done_total = 0, busy_total = 0;
  logic [2:0] epipe;
  int ecol;

  logic [7:0] wq[$];
  logic [11:0] iq[$];
  logic [DW-1:0] kq[$];
  logic [COLW-1:0] cq[$];
  logic [6:0] tq[$];

  assign start = start_main | start_extra;
  assign eng_out_valid = epipe[2] | inject;
  assign out_ready = !(drop_en && (tag_total == drop_tag));

  function automatic logic [MW-1:0] word_at(logic [11:0] a);
    logic [MW-1:0] w;
    int c, r;
    w = '0;
    c = int'(a >> 1);
    for (int l = 0; l < 16; l++) begin
      r = int'(a[0]) * 16 + l;
      if (r < IMG && c < IMG) w[l*DW +: DW] = img[r][c];
      else w[l*DW +: DW] = 16'hBAD0 ^ 16'(l);
    end
    return w;
  endfunction

  function automatic logic [COLW-1:0] exp_col(int c);
    logic [COLW-1:0] v;
    for (int r = 0; r < IMG; r++) v[r*DW +: DW] = img[r][c];
    return v;
  endfunction

  // Memory models: one-cycle read latency.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      w_rd_data   <= '0;
      img_rd_data <= '0;
    end else begin
      if (w_rd_en) w_rd_data <= wmem[w_addr];
      if (img_rd_en) img_rd_data <= word_at(img_addr);
    end
  end

  // Engine model: output column j-(KS-1) emerges 3 cycles after input column j.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      epipe <= '0;
      ecol  <= 0;
    end else begin
      epipe <= {epipe[1:0], eng_col_valid && (ecol >= KS - 1)};
      if (eng_kernel_load) ecol <= 0;
      else if (eng_col_valid) ecol <= ecol + 1;
    end
  end

  always @(negedge clk) begin
    if (w_rd_en) wq.push_back(w_addr);
    if (img_rd_en) iq.push_back(img_addr);
    if (eng_kernel_load) kq.push_back(eng_weight);
    if (eng_col_valid) cq.push_back(eng_col);
    if (out_valid) begin
      tq.push_back({out_ch, out_col});
      tag_total++;
    end
    if (done) done_total++;
    if (busy) busy_total++;
  end

  always @(negedge clk) begin
    start_extra = dist_en && img_rd_en && (img_addr == 12'd10);
    inject      = dist_en && w_rd_en && (w_addr == 8'd30);
  end

  task automatic check(input string tag, input logic [COLW-1:0] obs, input logic [COLW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < 256; i++) wmem[i] = 16'($urandom);
    for (int r = 0; r < IMG; r++)
      for (int c = 0; c < IMG; c++) img[r][c] = 16'($urandom);
  endtask

  int exp_chc = 0;

  task automatic run_layer(input logic expect_err);
    int bw, bi, bk, bc, bt, bd, bb, n;
    bw = wq.size(); bi = iq.size(); bk = kq.size(); bc = cq.size(); bt = tq.size();
    bd = done_total; bb = busy_total;
    @(negedge clk) start_main = 1'b1;
    @(negedge clk) start_main = 1'b0;
    check("err_cleared_on_start", err, 1'b0);
    check("busy_after_start", busy, 1'b1);
    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done, 1'b1);
    @(negedge clk);
    check("busy_low_after_done", busy, 1'b0);
    check("done_one_cycle", done, 1'b0);
    check("done_count", 64'(done_total - bd), 64'd1);
    check("w_read_count", 64'(wq.size() - bw), 64'(NCH * KK));
    check("img_read_count", 64'(iq.size() - bi), 64'(NCH * 2 * IMG));
    check("kload_count", 64'(kq.size() - bk), 64'(NCH * KK));
    check("col_count", 64'(cq.size() - bc), 64'(NCH * IMG));
    check("tag_count", 64'(tq.size() - bt), 64'(NCH * NOUT));
    for (int j = 0; j < NCH * KK && bw + j < wq.size(); j++) check("w_addr", wq[bw + j], 8'(j));
    for (int j = 0; j < NCH * 2 * IMG && bi + j < iq.size(); j++)
      check("img_addr", iq[bi + j], 12'(j % (2 * IMG)));
    for (int j = 0; j < NCH * KK && bk + j < kq.size(); j++) check("eng_weight", kq[bk + j], wmem[j]);
    for (int j = 0; j < NCH * IMG && bc + j < cq.size(); j++) check("eng_col", cq[bc + j], exp_col(j % IMG));
    for (int j = 0; j < NCH * NOUT && bt + j < tq.size(); j++)
      check("out_tag", tq[bt + j], {2'(j / NOUT), 5'(j % NOUT)});
    if (wq.size() > bw + 75) begin
      check("ch1_first_w_addr", wq[bw + 25], 8'd25);
      check("ch3_first_w_addr", wq[bw + 75], 8'd75);
    end
    check("err_final", err, expect_err);
    exp_chc += NCH;
`ifdef SCHED_PERF_EN
    check("cyc_count", cyc_count, 32'(busy_total - bb));
    check("ch_count", ch_count, 8'(exp_chc));
`endif
  endtask

  task automatic check_quiet(input string pfx);
    check({pfx, "_busy"}, busy, 1'b0);
    check({pfx, "_done"}, done, 1'b0);
    check({pfx, "_w_rd_en"}, w_rd_en, 1'b0);
    check({pfx, "_img_rd_en"}, img_rd_en, 1'b0);
    check({pfx, "_kload"}, eng_kernel_load, 1'b0);
    check({pfx, "_col_valid"}, eng_col_valid, 1'b0);
    check({pfx, "_out_valid"}, out_valid, 1'b0);
  endtask

  initial begin
    int strobes, n;
    rst = 1'b1;
    randomize_mem();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset then idle: everything quiet.
    strobes = 0;
    repeat (10) begin
      @(negedge clk);
      if (w_rd_en || img_rd_en || busy || done || eng_kernel_load || eng_col_valid || out_valid) strobes++;
    end
    check("idle_strobes", 64'(strobes), 64'd0);
    check_quiet("reset");
    check("reset_err", err, 1'b0);
    check("reset_w_addr", w_addr, 8'd0);
    check("reset_img_addr", img_addr, 12'd0);
    check("reset_eng_weight", eng_weight, 16'd0);
    check("reset_eng_col", eng_col, '0);
    check("reset_out_tag", {out_ch, out_col}, 7'd0);

    // Clean four-channel layer.
    run_layer(1'b0);

    // Writer refuses the third result: lost but counted, err sticks.
    randomize_mem();
    drop_en = 1'b1;
    drop_tag = tag_total + 2;
    run_layer(1'b1);
    drop_en = 1'b0;

    // Stray start during FETCH and a stray engine result during LOAD_W.
    randomize_mem();
    dist_en = 1'b1;
    run_layer(1'b1);
    dist_en = 1'b0;
    repeat (3) @(negedge clk);

    // Reset mid-FETCH at column 10, then a fresh layer.
    @(negedge clk) start_main = 1'b1;
    @(negedge clk) start_main = 1'b0;
    n = 0;
    while (!(img_rd_en === 1'b1 && img_addr == 12'd20) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("reached_col10", img_addr, 12'd20);
    rst = 1'b1;
    @(negedge clk);
    check_quiet("midrst");
    check("midrst_err", err, 1'b0);
    rst = 1'b0;
    exp_chc = 0;
    repeat (6) @(negedge clk);
    check_quiet("post_rst");
    randomize_mem();
    run_layer(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
